// File: rtl/sig_bist_checker_pkg.sv
// Purpose: shared constants and the signature step for the signature BIST checker.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package sig_bist_checker_pkg;

    localparam int SIG_W  = 16;
    localparam int DATA_W = 8;

    // FSM encoding, kept as plain constants so older tools see a 2-bit vector.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Final stimulus value; issued but never sampled.
    localparam logic [DATA_W-1:0] STIM_LAST = 8'hFF;

    // One compaction step: scramble the response with the seed, add it into
    // the low byte (carry dropped), then rotate left by one.
    function automatic logic [SIG_W-1:0] sig_step(
        input logic [SIG_W-1:0]  acc,
        input logic [DATA_W-1:0] seed,
        input logic [DATA_W-1:0] resp
    );
        logic [DATA_W-1:0] scr;
        logic [DATA_W-1:0] sum;
        scr = seed ^ resp;
        sum = acc[7:0] + scr;
        return {acc[14:8], sum, acc[15]};
    endfunction

endpackage

// File: rtl/sig_bist_checker_compactor.sv
// Purpose: 16-bit seed-scrambled add-and-rotate response compactor.
// Latency: one cycle from en=1 to the updated signature.
// Backpressure: none; every enabled cycle consumes one response.
module sig_compactor
    import sig_bist_checker_pkg::*;
(
    input  logic              clk,
    input  logic              clear_n,
    input  logic              init,
    input  logic              en,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] r_acc;

    // Accumulator: init wins over en so a relaunch always starts from zero.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_acc <= '0;
        end else if (init) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= sig_step(r_acc, seed, resp);
        end
    end

    assign sig = r_acc;

endmodule

// File: rtl/sig_bist_checker.sv
// Purpose: on-chip stimulus generator, response compactor and golden compare.
// Latency: done rises 256+LATENCY cycles after the accepted start edge.
// Backpressure: start is ignored while busy; no flow control toward the CUT.
module sig_bist_checker
    import sig_bist_checker_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic [SIG_W-1:0]  golden,
    output logic [DATA_W-1:0] dut_stim,
    input  logic [DATA_W-1:0] dut_resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature
);

    localparam logic [2:0] LAT3 = 3'(LATENCY);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_stim;
    logic [DATA_W-1:0] r_seed;
    logic [SIG_W-1:0]  r_golden;
    logic [2:0]        r_drain;
    logic              r_pass;

    logic              w_start_acc;
    logic              w_tag_in;
    logic              w_acc_en;
    logic [SIG_W-1:0]  w_sig;

    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // Stimuli 0x00..0xFE are tagged; 0xFF is only a parking value.
    assign w_tag_in    = (r_state == ST_RUN) && (r_stim != STIM_LAST);

    generate
        if (LATENCY == 0) begin : g_nopipe
            assign w_acc_en = w_tag_in;
        end else begin : g_pipe
            logic [LATENCY-1:0] r_vld;

            // Valid-tag delay line matching the CUT response latency.
            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n) begin
                    r_vld <= '0;
                end else if (w_start_acc) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_tag_in;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            assign w_acc_en = r_vld[LATENCY-1];
        end
    endgenerate

    // Control FSM with stimulus counter, captured operands and drain counter.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state  <= ST_IDLE;
            r_stim   <= '0;
            r_seed   <= '0;
            r_golden <= '0;
            r_drain  <= '0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_stim   <= '0;
                        r_seed   <= seed;
                        r_golden <= golden;
                        r_pass   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_stim != STIM_LAST) begin
                        r_stim <= r_stim + 8'd1;
                    end
                    if (r_stim == (STIM_LAST - 8'd1)) begin
                        r_state <= ST_DRAIN;
                        r_drain <= '0;
                    end
                end
                ST_DRAIN: begin
                    // The last tagged sample lands on the LATENCY-th drain edge;
                    // compare on the edge after that.
                    if (r_drain == LAT3) begin
                        r_state <= ST_DONE;
                        r_pass  <= (w_sig == r_golden);
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sig_compactor u_comp (
        .clk     (clk),
        .clear_n (clear_n),
        .init    (w_start_acc),
        .en      (w_acc_en),
        .seed    (r_seed),
        .resp    (dut_resp),
        .sig     (w_sig)
    );

    assign dut_stim  = r_stim;
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign signature = w_sig;

endmodule

// File: tb/tb_sig_bist_checker.sv
// Purpose: scoreboard bench for sig_bist_checker at LATENCY 0 and 2.
// Latency: expects done at edge 256+LATENCY after the start edge.
// Backpressure: exercises start-while-busy and start held through DONE.
module tb_sig_bist_checker;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
    } sb_item_t;

    logic        clk;
    logic        clear_n;
    logic        start;
    logic [7:0]  seed;
    logic [15:0] golden;

    logic [7:0]  stim0, resp0, stim2, resp2;
    logic        busy0, done0, pass0, busy2, done2, pass2;
    logic [15:0] sig0, sig2;
    logic [7:0]  d2a, d2b;

    bit          sel;        // 0: LATENCY=0 instance, 1: LATENCY=2 instance
    bit          hold;       // keep start asserted between tasks
    logic [7:0]  cur_seed;
    logic [15:0] cur_gold;
    bit          cur_id;     // 1: CUT echoes stimulus, 0: CUT returns cur_cv
    logic [7:0]  cur_cv;

    int          n_chk;
    int          n_err;
    sb_item_t    exp_q[$];

    logic        w_busy, w_done, w_pass;
    logic [7:0]  w_stim;
    logic [15:0] w_sig;

    assign resp0  = cur_id ? stim0 : cur_cv;
    assign resp2  = d2b;
    assign w_busy = sel ? busy2 : busy0;
    assign w_done = sel ? done2 : done0;
    assign w_pass = sel ? pass2 : pass0;
    assign w_stim = sel ? stim2 : stim0;
    assign w_sig  = sel ? sig2  : sig0;

    sig_bist_checker #(.LATENCY(0)) u_dut0 (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start && !sel),
        .seed      (seed),
        .golden    (golden),
        .dut_stim  (stim0),
        .dut_resp  (resp0),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
        .signature (sig0)
    );

    sig_bist_checker #(.LATENCY(2)) u_dut2 (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start && sel),
        .seed      (seed),
        .golden    (golden),
        .dut_stim  (stim2),
        .dut_resp  (resp2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .signature (sig2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-stage registered identity CUT for the LATENCY=2 instance.
    initial begin
        d2a = 8'h00;
        d2b = 8'h00;
    end
    always @(posedge clk) begin
        d2a <= stim2;
        d2b <= d2a;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference compactor over the first cnt samples of a run.
    function automatic logic [15:0] model_sig(input logic [7:0] sd, input bit id_mode,
                                              input logic [7:0] cv, input int cnt);
        logic [15:0] acc;
        logic [7:0]  r;
        logic [7:0]  sum;
        acc = 16'h0000;
        for (int s = 0; s < cnt; s++) begin
            r   = id_mode ? 8'(s) : cv;
            sum = acc[7:0] + (sd ^ r);
            acc = {acc[14:8], sum, acc[15]};
        end
        return acc;
    endfunction

    function automatic sb_item_t expect_item(input logic [15:0] gold);
        sb_item_t it;
        it.sig  = model_sig(cur_seed, cur_id, cur_cv, 255);
        it.pass = (it.sig == gold);
        return it;
    endfunction

    task automatic launch(input logic [7:0] sd, input logic [15:0] gold,
                          input bit id_mode, input logic [7:0] cv);
        cur_seed = sd;
        cur_gold = gold;
        cur_id   = id_mode;
        cur_cv   = cv;
        seed     = sd;
        golden   = gold;
        exp_q.push_back(expect_item(gold));
        start = 1'b1;
        tick();
        start = hold;
        check("e0_busy", w_busy, 1);
        check("e0_done", w_done, 0);
        check("e0_stim", w_stim, 0);
        check("e0_sig",  w_sig,  0);
    endtask

    task automatic finish(input bit disturb);
        int       n;
        int       lat;
        int       ns;
        sb_item_t it;
        lat = sel ? 2 : 0;
        n   = 0;
        while (w_done !== 1'b1 && n < 400) begin
            if (disturb && n == 99) begin
                start  = 1'b1;
                seed   = ~cur_seed;
                golden = ~cur_gold;
            end else begin
                start = hold;
            end
            tick();
            n++;
            if (n == 1 || n == 2 || n == 3 || n == 100 || n == 200) begin
                ns = n - lat;
                if (ns < 0) ns = 0;
                if (ns > 255) ns = 255;
                check($sformatf("sig_e%0d", n), w_sig, model_sig(cur_seed, cur_id, cur_cv, ns));
            end
            if (!sel && !cur_id && cur_cv == 8'h01 && cur_seed == 8'h00) begin
                if (n == 1) check("sig_e1_const", w_sig, 16'h0002);
                if (n == 2) check("sig_e2_const", w_sig, 16'h0006);
            end
            if (n == 254) check("stim_e254", w_stim, 8'hFE);
            if (n == 255) begin
                check("stim_e255", w_stim, 8'hFF);
                check("busy_e255", w_busy, 1);
            end
        end
        start = hold;
        check("done_edge", n, 256 + lat);
        check("busy_at_done", w_busy, 0);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: result seen, expected none");
        end else begin
            it = exp_q.pop_front();
            check("final_sig",  w_sig,  it.sig);
            check("final_pass", w_pass, it.pass);
            if (!hold) begin
                tick();
                check("done_hold", w_done, 1);
                check("pass_hold", w_pass, it.pass);
                check("sig_hold",  w_sig,  it.sig);
                check("stim_hold", w_stim, 8'hFF);
            end
        end
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        sel      = 1'b0;
        hold     = 1'b0;
        cur_seed = 8'h00;
        cur_gold = 16'h0000;
        cur_id   = 1'b0;
        cur_cv   = 8'h00;
        clear_n  = 1'b0;
        start    = 1'b0;
        seed     = 8'h00;
        golden   = 16'h0000;
        #2;
        check("rst_stim", stim0, 0);
        check("rst_sig",  sig0,  0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        #20 clear_n = 1'b1;
        tick();

        // Scrambler cancels the response: signature stays zero.
        launch(8'h5A, 16'h0000, 1'b0, 8'h5A);
        finish(1'b0);

        // Constant 0x01 response, matching and off-by-one golden.
        launch(8'h00, model_sig(8'h00, 1'b0, 8'h01, 255), 1'b0, 8'h01);
        finish(1'b0);
        launch(8'h00, model_sig(8'h00, 1'b0, 8'h01, 255) ^ 16'h0001, 1'b0, 8'h01);
        finish(1'b0);

        // Identity CUT at LATENCY=0 and LATENCY=2 give the same signature.
        launch(8'hAA, model_sig(8'hAA, 1'b1, 8'h00, 255), 1'b1, 8'h00);
        finish(1'b0);
        sel = 1'b1;
        launch(8'hAA, model_sig(8'hAA, 1'b1, 8'h00, 255), 1'b1, 8'h00);
        finish(1'b0);
        sel = 1'b0;

        // start with a different seed/golden at E100 must be ignored.
        launch(8'h3C, model_sig(8'h3C, 1'b1, 8'h00, 255), 1'b1, 8'h00);
        finish(1'b1);

        // Half-cycle reset mid-run aborts; a fresh run then completes.
        launch(8'h77, model_sig(8'h77, 1'b1, 8'h00, 255), 1'b1, 8'h00);
        for (int i = 0; i < 300 && stim0 !== 8'h40; i++) tick();
        check("abort_at_40", stim0, 8'h40);
        clear_n = 1'b0;
        #1;
        check("abort_stim", w_stim, 0);
        check("abort_sig",  w_sig,  0);
        check("abort_busy", w_busy, 0);
        check("abort_done", w_done, 0);
        check("abort_pass", w_pass, 0);
        #4 clear_n = 1'b1;
        void'(exp_q.pop_back());
        tick();
        check("idle_done", w_done, 0);
        check("idle_stim", w_stim, 0);
        launch(8'h77, model_sig(8'h77, 1'b1, 8'h00, 255) ^ 16'h8000, 1'b1, 8'h00);
        finish(1'b0);

        // start held high: done lasts one cycle and the next run restarts clean.
        hold = 1'b1;
        launch(8'h19, model_sig(8'h19, 1'b0, 8'hC3, 255), 1'b0, 8'hC3);
        finish(1'b0);
        exp_q.push_back(expect_item(cur_gold));
        tick();
        check("relaunch_done", w_done, 0);
        check("relaunch_busy", w_busy, 1);
        check("relaunch_stim", w_stim, 0);
        check("relaunch_sig",  w_sig,  0);
        check("relaunch_pass", w_pass, 0);
        hold  = 1'b0;
        start = 1'b0;
        finish(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
